// File: rtl/layer_pulse_pkg.sv
// layer_pulse_pkg: state encoding, default widths and config helpers shared by
// layer_pulse_unit and fallback_monitor.
package layer_pulse_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_REP_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH,
        LOW
    } state_e;

    // High and low phase lengths of zero would stall the sequence, so they run as one cycle.
    function automatic logic [31:0] clamp_min1(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/fallback_monitor.sv
// fallback_monitor: watches io_fallback for a rising edge inside a window opened at the first pulse rise.
// Build option FALLBACK_SYNC_EN inserts a 2-flop synchronizer ahead of the edge detector.
module fallback_monitor
    import layer_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             open_start,
    input  logic [CNT_W-1:0] window,
    input  logic             fallback_in,
    output logic             catch_strobe,
    output logic             timeout_strobe
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             fb_sampled;
    logic             fb_prev_q;
    logic             fb_rise;
    logic             start_open;
    logic             win_open;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic             fb_catch_q, fb_catch_d;
    logic             fb_timeout_q, fb_timeout_d;

`ifdef FALLBACK_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= fallback_in;
            sync2_q <= sync1_q;
        end
    end

    assign fb_sampled = sync2_q;
`else
    assign fb_sampled = fallback_in;
`endif

    assign fb_rise    = fb_sampled & ~fb_prev_q;
    assign start_open = open_start && (window != '0);
    assign win_open   = start_open || (win_cnt_q != '0);

    // win_cnt_q holds the window cycles still to come after the current one.
    always_comb begin
        win_cnt_d    = win_cnt_q;
        fb_catch_d   = 1'b0;
        fb_timeout_d = 1'b0;

        if (clear) begin
            win_cnt_d = '0;
        end else if (win_open && fb_rise) begin
            fb_catch_d = 1'b1;
            win_cnt_d  = '0;
        end else if (start_open) begin
            win_cnt_d    = window - CNT_ONE;
            fb_timeout_d = (window == CNT_ONE);
        end else if (win_cnt_q != '0) begin
            win_cnt_d    = win_cnt_q - CNT_ONE;
            fb_timeout_d = (win_cnt_q == CNT_ONE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fb_prev_q    <= 1'b0;
            win_cnt_q    <= '0;
            fb_catch_q   <= 1'b0;
            fb_timeout_q <= 1'b0;
        end else begin
            fb_prev_q    <= fb_sampled;
            win_cnt_q    <= win_cnt_d;
            fb_catch_q   <= fb_catch_d;
            fb_timeout_q <= fb_timeout_d;
        end
    end

    assign catch_strobe   = fb_catch_q;
    assign timeout_strobe = fb_timeout_q;

endmodule

// File: rtl/layer_pulse_unit.sv
// layer_pulse_unit: one pulse-generator layer producing a delayed, shaped, repeated pulse train
// plus per-layer status strobes. Build option FALLBACK_SYNC_EN synchronizes io_fallback.
module layer_pulse_unit
    import layer_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_pulseEn,
    input  logic             io_abort,
    input  logic [CNT_W-1:0] io_cfgDelay,
    input  logic [CNT_W-1:0] io_cfgHigh,
    input  logic [CNT_W-1:0] io_cfgLow,
    input  logic [REP_W-1:0] io_cfgRepeat,
    input  logic             io_cfgLast,
    input  logic [CNT_W-1:0] io_cfgFbWindow,
    input  logic             io_fallback,
    output logic             io_pulse,
    output logic             io_busy,
    output logic             io_layerEnd,
    output logic             io_layerLast,
    output logic             io_triggerDelay,
    output logic             io_fbDelay,
    output logic             io_fallbackCatch
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    localparam logic [REP_W-1:0] REP_ZERO = '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] window_q, window_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             layer_end_q, layer_end_d;
    logic             layer_last_q, layer_last_d;
    logic             trigger_q, trigger_d;
    logic             accept;
    logic [CNT_W-1:0] cfg_high_clamped;
    logic [CNT_W-1:0] cfg_low_clamped;

    assign cfg_high_clamped = CNT_W'(clamp_min1(32'(io_cfgHigh)));
    assign cfg_low_clamped  = CNT_W'(clamp_min1(32'(io_cfgLow)));

    // cnt_q counts the cycles left in the current phase, including the present one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rep_d        = rep_q;
        high_d       = high_q;
        low_d        = low_q;
        window_d     = window_q;
        pulse_d      = pulse_q;
        busy_d       = busy_q;
        layer_last_d = layer_last_q;
        layer_end_d  = 1'b0;
        trigger_d    = 1'b0;
        accept       = 1'b0;

        if (io_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                    if (io_pulseEn) begin
                        accept       = 1'b1;
                        busy_d       = 1'b1;
                        high_d       = cfg_high_clamped;
                        low_d        = cfg_low_clamped;
                        rep_d        = io_cfgRepeat;
                        window_d     = io_cfgFbWindow;
                        layer_last_d = io_cfgLast;
                        if (io_cfgDelay == '0) begin
                            state_d   = HIGH;
                            cnt_d     = cfg_high_clamped;
                            pulse_d   = 1'b1;
                            trigger_d = 1'b1;
                        end else begin
                            state_d = DELAY;
                            cnt_d   = io_cfgDelay;
                        end
                    end
                end

                DELAY: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d   = HIGH;
                        cnt_d     = high_q;
                        pulse_d   = 1'b1;
                        trigger_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                HIGH: begin
                    if (cnt_q == CNT_ONE) begin
                        pulse_d = 1'b0;
                        if (rep_q == REP_ZERO) begin
                            state_d     = IDLE;
                            cnt_d       = '0;
                            busy_d      = 1'b0;
                            layer_end_d = 1'b1;
                        end else begin
                            state_d = LOW;
                            cnt_d   = low_q;
                            rep_d   = rep_q - REP_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                LOW: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = HIGH;
                        cnt_d   = high_q;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rep_q        <= '0;
            high_q       <= '0;
            low_q        <= '0;
            window_q     <= '0;
            pulse_q      <= 1'b0;
            busy_q       <= 1'b0;
            layer_end_q  <= 1'b0;
            layer_last_q <= 1'b0;
            trigger_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rep_q        <= rep_d;
            high_q       <= high_d;
            low_q        <= low_d;
            window_q     <= window_d;
            pulse_q      <= pulse_d;
            busy_q       <= busy_d;
            layer_end_q  <= layer_end_d;
            layer_last_q <= layer_last_d;
            trigger_q    <= trigger_d;
        end
    end

    // A new accept or an abort closes any window still running from the previous sequence.
    fallback_monitor #(
        .CNT_W(CNT_W)
    ) u_fallback_monitor (
        .clock         (clock),
        .reset         (reset),
        .clear         (io_abort | accept),
        .open_start    (trigger_q),
        .window        (window_q),
        .fallback_in   (io_fallback),
        .catch_strobe  (io_fallbackCatch),
        .timeout_strobe(io_fbDelay)
    );

    assign io_pulse        = pulse_q;
    assign io_busy         = busy_q;
    assign io_layerEnd     = layer_end_q;
    assign io_layerLast    = layer_last_q;
    assign io_triggerDelay = trigger_q;

endmodule

// File: tb/tb_layer_pulse_unit.sv
// tb_layer_pulse_unit: directed and randomized stimulus, an interval-based reference model
// and a per-cycle scoreboard comparing all layer_pulse_unit outputs.
module tb_layer_pulse_unit;

    localparam int CNT_W   = 16;
    localparam int REP_W   = 8;
    localparam int NC      = 4000;
    localparam int RST_CYC = 3;
`ifdef FALLBACK_SYNC_EN
    localparam int FB_LAT = 2;
`else
    localparam int FB_LAT = 0;
`endif

    localparam int B_PULSE = 6;
    localparam int B_BUSY  = 5;
    localparam int B_END   = 4;
    localparam int B_LAST  = 3;
    localparam int B_TRIG  = 2;
    localparam int B_FBD   = 1;
    localparam int B_CATCH = 0;

    logic             clock = 1'b0;
    logic             reset;
    logic             io_pulseEn;
    logic             io_abort;
    logic [CNT_W-1:0] io_cfgDelay;
    logic [CNT_W-1:0] io_cfgHigh;
    logic [CNT_W-1:0] io_cfgLow;
    logic [REP_W-1:0] io_cfgRepeat;
    logic             io_cfgLast;
    logic [CNT_W-1:0] io_cfgFbWindow;
    logic             io_fallback;
    logic             io_pulse;
    logic             io_busy;
    logic             io_layerEnd;
    logic             io_layerLast;
    logic             io_triggerDelay;
    logic             io_fbDelay;
    logic             io_fallbackCatch;

    layer_pulse_unit #(
        .CNT_W(CNT_W),
        .REP_W(REP_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_pulseEn      (io_pulseEn),
        .io_abort        (io_abort),
        .io_cfgDelay     (io_cfgDelay),
        .io_cfgHigh      (io_cfgHigh),
        .io_cfgLow       (io_cfgLow),
        .io_cfgRepeat    (io_cfgRepeat),
        .io_cfgLast      (io_cfgLast),
        .io_cfgFbWindow  (io_cfgFbWindow),
        .io_fallback     (io_fallback),
        .io_pulse        (io_pulse),
        .io_busy         (io_busy),
        .io_layerEnd     (io_layerEnd),
        .io_layerLast    (io_layerLast),
        .io_triggerDelay (io_triggerDelay),
        .io_fbDelay      (io_fbDelay),
        .io_fallbackCatch(io_fallbackCatch)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [6:0] bits;
    } exp_t;

    logic       pe_a   [NC];
    logic       ab_a   [NC];
    logic       fb_a   [NC];
    logic       last_a [NC];
    int         d_a    [NC];
    int         h_a    [NC];
    int         l_a    [NC];
    int         r_a    [NC];
    int         w_a    [NC];
    logic [6:0] exp_a  [NC];
    exp_t       exp_q  [$];

    int check_count = 0;
    int pass_count  = 0;
    int cur;

    // Model state for the sequence currently owning the layer.
    logic have;
    int   acc_c;
    int   s_d;
    int   s_h;
    int   s_l;
    int   s_r;
    int   s_w;
    logic s_last;
    int   abort_at;
    int   seq_end_cur;

    task automatic dir_seg(input int d, input int h, input int l, input int r, input int w,
                           input logic lst, input int len, output int base);
        base = cur;
        for (int i = 0; i < len; i++) begin
            pe_a[cur + i] = 1'b0;
            ab_a[cur + i] = 1'b0;
            fb_a[cur + i] = 1'b0;
        end
        pe_a[cur]   = 1'b1;
        d_a[cur]    = d;
        h_a[cur]    = h;
        l_a[cur]    = l;
        r_a[cur]    = r;
        w_a[cur]    = w;
        last_a[cur] = lst;
        cur += len;
    endtask

    task automatic fb_high(input int from, input int to);
        for (int i = from; i <= to; i++) fb_a[i] = 1'b1;
    endtask

    function automatic logic fb_seen(input int t);
        if (t - FB_LAT < 0) return 1'b0;
        return fb_a[t - FB_LAT];
    endfunction

    function automatic logic rise_at(input int t);
        logic prev;
        prev = (t >= 1) ? fb_seen(t - 1) : 1'b0;
        return fb_seen(t) & ~prev;
    endfunction

    // Paint the outputs of one accepted sequence, cut short by an abort or the next accept.
    task automatic render_seq(input int nxt);
        int  ks, kw, ws, st, hi_end;
        logic caught;
        ks = (abort_at < 0) ? NC + 10 : abort_at;
        kw = (ks < nxt) ? ks : nxt;
        hi_end = (nxt < NC - 1) ? nxt : NC - 1;
        for (int t = acc_c + 1; t <= hi_end; t++) exp_a[t][B_LAST] = s_last;
        for (int t = acc_c + 1; t < seq_end_cur && t < NC && t <= ks; t++) exp_a[t][B_BUSY] = 1'b1;
        if (seq_end_cur <= ks && seq_end_cur < NC) exp_a[seq_end_cur][B_END] = 1'b1;
        for (int k = 0; k <= s_r; k++) begin
            st = acc_c + 1 + s_d + k * (s_h + s_l);
            for (int t = st; t < st + s_h; t++)
                if (t <= ks && t < NC) exp_a[t][B_PULSE] = 1'b1;
        end
        ws = acc_c + 1 + s_d;
        if (ws <= ks && ws < NC) exp_a[ws][B_TRIG] = 1'b1;
        if (s_w > 0 && ws <= ks) begin
            caught = 1'b0;
            for (int t = ws; t < ws + s_w; t++) begin
                if (t >= kw || t >= NC) break;
                if (rise_at(t)) begin
                    if (t + 1 < NC) exp_a[t + 1][B_CATCH] = 1'b1;
                    caught = 1'b1;
                    break;
                end
            end
            if (!caught && ws + s_w <= kw && ws + s_w < NC) exp_a[ws + s_w][B_FBD] = 1'b1;
        end
    endtask

    task automatic run_model();
        for (int t = 0; t < NC; t++) exp_a[t] = '0;
        have     = 1'b0;
        abort_at = -1;
        for (int c = 0; c < NC; c++) begin
            if (ab_a[c]) begin
                if (have && abort_at < 0) abort_at = c;
            end else if (pe_a[c] && (!have || c >= seq_end_cur || abort_at >= 0)) begin
                if (have) render_seq(c);
                have        = 1'b1;
                acc_c       = c;
                s_d         = d_a[c];
                s_h         = (h_a[c] == 0) ? 1 : h_a[c];
                s_l         = (l_a[c] == 0) ? 1 : l_a[c];
                s_r         = r_a[c];
                s_w         = w_a[c];
                s_last      = last_a[c];
                abort_at    = -1;
                seq_end_cur = acc_c + 1 + s_d + (s_r + 1) * s_h + s_r * s_l;
            end
        end
        if (have) render_seq(NC);
    endtask

    task automatic build_stimulus();
        int base;
        for (int c = 0; c < NC; c++) begin
            if (c <= RST_CYC) begin
                pe_a[c] = 1'b0; ab_a[c] = 1'b0; fb_a[c] = 1'b0; last_a[c] = 1'b0;
                d_a[c] = 0; h_a[c] = 0; l_a[c] = 0; r_a[c] = 0; w_a[c] = 0;
            end else begin
                pe_a[c]   = ($urandom_range(0, 3) == 0);
                ab_a[c]   = ($urandom_range(0, 39) == 0);
                fb_a[c]   = ($urandom_range(0, 5) == 0) ? ~fb_a[c - 1] : fb_a[c - 1];
                last_a[c] = 1'($urandom_range(0, 1));
                d_a[c]    = int'($urandom_range(0, 6));
                h_a[c]    = int'($urandom_range(0, 4));
                l_a[c]    = int'($urandom_range(0, 4));
                r_a[c]    = int'($urandom_range(0, 3));
                w_a[c]    = int'($urandom_range(0, 20));
            end
        end
        cur = RST_CYC + 1;
        dir_seg(3, 2, 1, 0, 0, 1'b0, 10, base);
        dir_seg(0, 2, 3, 2, 0, 1'b0, 16, base);
        dir_seg(0, 1, 0, 0, 10, 1'b0, 14, base);
        fb_high(base + 5, base + 7);
        dir_seg(0, 1, 0, 0, 10, 1'b0, 14, base);
        dir_seg(0, 5, 0, 0, 8, 1'b0, 12, base);
        ab_a[base + 2] = 1'b1;
        dir_seg(1, 1, 0, 0, 0, 1'b0, 10, base);
        for (int i = 0; i <= 4; i++) begin
            pe_a[base + i] = 1'b1;
            d_a[base + i] = 1; h_a[base + i] = 1; r_a[base + i] = 0; w_a[base + i] = 0;
        end
        dir_seg(0, 2, 0, 0, 0, 1'b1, 4, base);
        ab_a[base] = 1'b1;
        dir_seg(0, 0, 0, 1, 0, 1'b1, 8, base);
        dir_seg(0, 1, 0, 0, 1, 1'b0, 6, base);
        fb_high(base + 1, base + 2);
        dir_seg(2, 1, 0, 0, 4, 1'b0, 10, base);
        fb_high(base, base + 9);
        dir_seg(0, 0, 0, 255, 0, 1'b1, 515, base);
        dir_seg(0, 1, 0, 0, 12, 1'b0, 16, base);
        ab_a[base + 5] = 1'b1;
        fb_high(base + 8, base + 9);
        dir_seg(0, 1, 0, 0, 6, 1'b0, 12, base);
        fb_high(base + 6, base + 7);
    endtask

    task automatic applyStimulus(input int c);
        reset          = (c < RST_CYC);
        io_pulseEn     = pe_a[c];
        io_abort       = ab_a[c];
        io_fallback    = fb_a[c];
        io_cfgLast     = last_a[c];
        io_cfgDelay    = CNT_W'(d_a[c]);
        io_cfgHigh     = CNT_W'(h_a[c]);
        io_cfgLow      = CNT_W'(l_a[c]);
        io_cfgRepeat   = REP_W'(r_a[c]);
        io_cfgFbWindow = CNT_W'(w_a[c]);
    endtask

    task automatic checkOutput(input exp_t item);
        logic [6:0] act;
        act = {io_pulse, io_busy, io_layerEnd, io_layerLast, io_triggerDelay, io_fbDelay, io_fallbackCatch};
        check_count++;
        if (act === item.bits) pass_count++;
        else $display("[TB] FAIL cycle %0d outputs(pulse,busy,end,last,trig,fbd,catch): got %b expected %b",
                      item.cyc, act, item.bits);
    endtask

    always @(negedge clock) begin
        exp_t item;
        if (exp_q.size() != 0) begin
            item = exp_q.pop_front();
            checkOutput(item);
        end
    end

    initial begin
        exp_t item;
        reset = 1'b1;
        io_pulseEn = 1'b0; io_abort = 1'b0; io_fallback = 1'b0; io_cfgLast = 1'b0;
        io_cfgDelay = '0; io_cfgHigh = '0; io_cfgLow = '0; io_cfgRepeat = '0; io_cfgFbWindow = '0;
        build_stimulus();
        run_model();
        $display("[TB] running %0d cycles, fallback latency %0d", NC, FB_LAT);
        for (int c = 0; c < NC; c++) begin
            @(posedge clock);
            #1;
            applyStimulus(c);
            if (c >= 1) begin
                item.cyc  = c;
                item.bits = exp_a[c];
                exp_q.push_back(item);
            end
        end
        repeat (2) @(negedge clock);
        #1;
        check_count++;
        if (exp_q.size() == 0) pass_count++;
        else $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
